// File: rtl/pwm_output_peripheral_if.sv
// -----------------------------------------------------------------------------
// pwm_output_peripheral_if
//   Address/control half of the shared 8-bit microprocessor bus.
//
//   Signals:
//     BUS_ADDR  8  bus address, driven by the processor
//     BUS_WE    1  1 = processor write, 0 = read
//
//   Modports:
//     master  processor side (drives address and write enable)
//     slave   peripheral side (samples address and write enable)
//
//   BUS_DATA is not carried here. It is a tristate net with several drivers,
//   so it stays a plain inout on each peripheral. Every driver then resolves
//   onto one wire at the level where the bus is built.
// -----------------------------------------------------------------------------
interface pwm_output_peripheral_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;

  modport master (output BUS_ADDR, output BUS_WE);
  modport slave  (input  BUS_ADDR, input  BUS_WE);
endinterface

// File: rtl/pwm_output_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_output_peripheral
//   Bus-mapped PWM generator. The processor writes a duty byte and a control
//   byte. The block drives one registered PWM waveform. All registers read
//   back with registered tristate timing: the block drives the bus in the
//   cycle after the address is presented.
//
//   Register window, relative to PwmBaseAddress:
//     +0 DUTY    duty shadow; copied into the active duty at the period wrap
//     +1 CTRL    [0] EN, [1] INV, [3:2] spare R/W, [7:4] PRESCALE
//     +2 STATUS  [0] WRAP (sticky, cleared by a read), [7:1] read as 0
//
//   Ports:
//     CLK       system clock; every flop uses the rising edge
//     RESET     synchronous, active-high reset
//     bus       address / write-enable half of the bus (slave modport)
//     BUS_DATA  shared data bus; driven only while returning read data
//     PWM_OUT   registered PWM waveform
// -----------------------------------------------------------------------------
module pwm_output_peripheral #(
  parameter logic [7:0] PwmBaseAddress = 8'hB0
) (
  input  logic                         CLK,
  input  logic                         RESET,
  pwm_output_peripheral_if.slave       bus,
  inout  wire  [7:0]                   BUS_DATA,
  output logic                         PWM_OUT
);

  // Register offsets inside the window.
  localparam logic [7:0] OffDuty   = 8'd0;
  localparam logic [7:0] OffCtrl   = 8'd1;
  localparam logic [7:0] OffStatus = 8'd2;

  // Programmer-visible state.
  logic [7:0] duty_shadow;
  logic [7:0] duty_active;
  logic [7:0] ctrl;
  logic       status_wrap;

  // Waveform generation state.
  logic [3:0] prescale_cnt;
  logic [7:0] pwm_cnt;

  // Registered read-back path.
  logic       drive_en;
  logic [7:0] out_reg;

  // Control fields.
  logic       en;
  logic       inv;
  logic [3:0] prescale;

  assign en       = ctrl[0];
  assign inv      = ctrl[1];
  assign prescale = ctrl[7:4];

  // The subtraction wraps modulo 256. Addresses below the base become large
  // offsets, so a single compare on the offset decodes the whole window.
  logic [7:0] offset;
  logic       read_hit;
  logic       status_read;

  assign offset      = bus.BUS_ADDR - PwmBaseAddress;
  assign read_hit    = !bus.BUS_WE && (offset <= OffStatus);
  assign status_read = !bus.BUS_WE && (offset == OffStatus);

  // The prescale counter is compared with equality. If PRESCALE drops below
  // the running count, the counter keeps counting up to 15. It then wraps
  // to 0 with no tick in between.
  logic tick;
  logic wrap;

  assign tick = en && (prescale_cnt == prescale);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // Read data is selected from the values held before this edge. A DUTY read
  // returns the shadow, not the duty currently being output.
  logic [7:0] read_mux;

  always_comb begin
    // NOTE: default assigned first so no path leaves read_mux unassigned (no latch).
    read_mux = 8'h00;
    case (offset)
      OffDuty:   read_mux = duty_shadow;
      OffCtrl:   read_mux = ctrl;
      OffStatus: read_mux = {7'b0, status_wrap};
      default:   read_mux = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every branch
  // below sees the values from before this edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      duty_shadow  <= 8'h00;
      duty_active  <= 8'h00;
      ctrl         <= 8'h00;
      status_wrap  <= 1'b0;
      prescale_cnt <= 4'd0;
      pwm_cnt      <= 8'd0;
      PWM_OUT      <= 1'b0;
      drive_en     <= 1'b0;
      out_reg      <= 8'h00;
    end else begin
      // Processor writes. STATUS is read-only, so writes to it are ignored.
      if (bus.BUS_WE && offset == OffDuty) duty_shadow <= BUS_DATA;
      if (bus.BUS_WE && offset == OffCtrl) ctrl        <= BUS_DATA;

      if (!en) begin
        // While disabled, the active duty follows the shadow. Re-enabling
        // then starts a fresh period with the latest duty.
        prescale_cnt <= 4'd0;
        pwm_cnt      <= 8'd0;
        duty_active  <= duty_shadow;
        PWM_OUT      <= inv;
      end else begin
        prescale_cnt <= tick ? 4'd0 : prescale_cnt + 4'd1;
        if (tick) pwm_cnt <= pwm_cnt + 8'd1;
        // Double buffering: the duty changes only at the period boundary.
        if (wrap) duty_active <= duty_shadow;
        PWM_OUT <= (pwm_cnt < duty_active) ^ inv;
      end

      // If a wrap and a STATUS read fall on the same edge, the set wins.
      if (wrap)             status_wrap <= 1'b1;
      else if (status_read) status_wrap <= 1'b0;

      drive_en <= read_hit;
      if (read_hit) out_reg <= read_mux;
    end
  end

  assign BUS_DATA = drive_en ? out_reg : 8'hZZ;

endmodule

// File: doc/pwm_output_peripheral.md
Name: pwm_output_peripheral

Overview:
- Bus-mapped, processor-writable output peripheral on the shared 8-bit microprocessor bus; the write-direction counterpart of the read-only switch input peripheral.
- The processor writes a duty byte and a control byte.
- The block generates a single PWM output, for a motor or LED drive on the RC platform.
- Registers read back on the same bus with the same registered tristate timing as the other bus peripherals.

Parameters:
- PwmBaseAddress, 8'hB0, base of a 3-byte register window (base+0 DUTY, base+1 CTRL, base+2 STATUS).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus; driven only during a read of this block, otherwise 8'hZZ.
- BUS_ADDR  input  8  bus address.
- BUS_WE  input  1  1 = processor write, 0 = read.
- PWM_OUT  output  1  registered PWM waveform.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RESET). All state below clears on a rising CLK edge with RESET=1.
- Reset values:
  - DUTY shadow = 0, active duty = 0, CTRL = 0, STATUS = 0.
  - Prescale counter = 0, PWM counter = 0.
  - PWM_OUT = 0, bus drive enable = 0, so BUS_DATA = Z.
- Write:
  - On an edge with BUS_WE=1 and BUS_ADDR in base..base+1, BUS_DATA is captured into DUTY shadow or CTRL on that same edge.
  - Writes to base+2 are ignored.
- Read (registered, 1-cycle latency):
  - On an edge with BUS_WE=0 and BUS_ADDR in base..base+2, the drive enable is set and the out register is loaded with the selected register.
  - The block drives BUS_DATA for the following cycle.
  - Any other address, or BUS_WE=1, clears the drive enable on the next edge.
  - DUTY reads return the shadow, not the active duty.
- CTRL fields:
  - bit0 EN.
  - bit1 INV (output polarity).
  - bits[7:4] PRESCALE (0–15).
  - bits[3:2] are writable and read back, with no function.
- Prescaler:
  - Counts 0..PRESCALE while EN=1.
  - tick = (prescale counter == PRESCALE), after which it returns to 0.
  - PRESCALE=0 gives tick every cycle.
- PWM counter:
  - 8-bit; increments on tick and wraps 255 -> 0.
  - Period = 256*(PRESCALE+1) clocks.
- Duty update:
  - Active duty loads from the shadow only on the tick where the counter is 255 (period wrap), or on any cycle with EN=0.
  - This gives glitch-free, double-buffered updates.
- Output:
  - With EN=1: PWM_OUT(next) = (counter < active duty) XOR INV.
  - Duty 0 gives a constant 0; duty 255 gives 255/256 high.
  - With EN=0: prescale counter and PWM counter are held at 0, and PWM_OUT(next) = INV.
  - PWM_OUT is registered, so it lags the counter by 1 cycle.
- Disable mid-period:
  - Takes effect on the edge after the CTRL write.
  - Re-enable starts a fresh period at counter 0 with the current shadow duty.
- PRESCALE change mid-count:
  - The new value is used immediately.
  - If the counter exceeds the new PRESCALE, it continues to 15 and then wraps to 0 (4-bit), with no tick generated in between.
- STATUS:
  - bit0 WRAP is sticky: set on each period wrap.
  - It is cleared on the edge that loads a STATUS read.
  - If a set and a clear fall on the same edge, set wins.
  - bits[7:1] read 0.
- A RESET asserted mid-period aborts immediately: all registers return to reset values on that edge.

Test Plan:
- Reset, then read base, base+1, base+2 -> each returns 8'h00 one cycle after the address. BUS_DATA is Z when another address (e.g. 8'hA8) is presented.
- Write DUTY=8'h40, then CTRL=8'h01 -> PWM_OUT high for exactly 64 of every 256 clocks, first rising edge 2 cycles after the CTRL write; read base -> 8'h40.
- Set CTRL=8'h31 (PRESCALE=3) with DUTY=8'h80 -> period 1024 clocks, high for 512. Write DUTY=8'h20 mid-period -> the current period keeps 512 high, the next period has 128 high.
- CTRL=8'h03 (INV) with DUTY=0 -> PWM_OUT constantly 1. Write CTRL=8'h02 -> PWM_OUT=1 and counters at 0. Write CTRL=8'h00 -> PWM_OUT=0 on the following edge.
- Enabled with PRESCALE=0, wait 256 clocks -> STATUS read = 8'h01, and an immediate second read = 8'h00. A read coinciding with a wrap edge leaves bit0 = 1.
- Assert RESET for 1 cycle mid-period with DUTY=8'hFF, EN=1 -> next edge PWM_OUT=0, all registers read 8'h00.
